// File: rtl/perceptron_pkg.sv
// Shared definitions for the perceptron trainer and classifier:
// default sizes, learning constants and the trainer FSM encoding.
package perceptron_pkg;

   localparam int unsigned     DEF_N_IN    = 16;
   localparam int unsigned     DEF_W_WIDTH = 8;
   localparam logic [7:0]      DEF_W_INIT  = 8'h80;
   localparam logic [7:0]      DEF_LR      = 8'd16;
   localparam logic [7:0]      SAT_MAX     = 8'hFF;

   typedef enum logic [2:0] {
      IDLE,
      ACCUM,
      DECIDE,
      UPDATE,
      DONE
   } state_t;

endpackage

// File: rtl/perceptron_trainer_sat_addsub.sv
// Combinational unsigned add/subtract that clamps to all-ones on overflow
// and to zero on underflow, using a one-bit-wider intermediate.
module sat_addsub import perceptron_pkg::*; #(
   parameter int unsigned W = DEF_W_WIDTH
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         sub,
   output logic [W-1:0] y
);

   logic [W:0] ext;

   always_comb begin
      ext = '0;
      y   = '0;
      if (sub) begin
         ext = {1'b0, a} - {1'b0, b};
         y   = ext[W] ? '0 : ext[W-1:0];
      end else begin
         ext = {1'b0, a} + {1'b0, b};
         y   = ext[W] ? '1 : ext[W-1:0];
      end
   end

endmodule

// File: rtl/perceptron_trainer.sv
// Online perceptron trainer: serial saturated accumulation over set bits,
// threshold prediction, and per-weight learning-rule update on error.
module perceptron_trainer import perceptron_pkg::*; #(
   parameter int unsigned          N_IN    = DEF_N_IN,
   parameter int unsigned          W_WIDTH = DEF_W_WIDTH,
   parameter logic [W_WIDTH-1:0]   LR      = DEF_LR,
   parameter logic [W_WIDTH-1:0]   THRESH  = 8'd255,
   parameter logic [W_WIDTH-1:0]   W_INIT  = DEF_W_INIT
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      sample_valid,
   output logic                      sample_ready,
   input  logic [N_IN-1:0]           sample_data,
   input  logic                      sample_label,
   output logic                      done_valid,
   output logic                      done_pred,
   output logic                      done_err,
   output logic                      busy,
   input  logic [$clog2(N_IN)-1:0]   weight_addr,
   output logic [W_WIDTH-1:0]        weight_data
);

   localparam int unsigned        IDX_W = $clog2(N_IN);
   localparam logic [IDX_W-1:0]   LAST  = IDX_W'(N_IN - 1);

   state_t               state, state_nxt;
   logic [N_IN-1:0]      data_q;
   logic                 label_q;
   logic [W_WIDTH-1:0]   sum;
   logic [IDX_W-1:0]     idx;
   logic                 pred_q, err_q;
   logic [W_WIDTH-1:0]   weights [N_IN];

   logic [W_WIDTH-1:0]   op_a, op_b, op_y;
   logic                 op_sub;
   logic                 pred_now;
   logic                 idx_last;

   assign pred_now = (sum >= THRESH);
   assign idx_last = (idx == LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (sample_valid) state_nxt = ACCUM;
         ACCUM:   if (idx_last)     state_nxt = DECIDE;
         DECIDE:  state_nxt = (pred_now ^ label_q) ? UPDATE : DONE;
         UPDATE:  if (idx_last)     state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // One saturating unit serves both phases: sum+weight in ACCUM, weight+/-LR in UPDATE.
   always_comb begin
      op_a   = sum;
      op_b   = weights[idx];
      op_sub = 1'b0;
      if (state == UPDATE) begin
         op_a   = weights[idx];
         op_b   = LR;
         op_sub = ~label_q;
      end
   end

   sat_addsub #(.W(W_WIDTH)) u_sat (
      .a   (op_a),
      .b   (op_b),
      .sub (op_sub),
      .y   (op_y)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q  <= '0;
         label_q <= 1'b0;
         sum     <= '0;
         idx     <= '0;
         pred_q  <= 1'b0;
         err_q   <= 1'b0;
         for (int unsigned i = 0; i < N_IN; i++) weights[i] <= W_INIT;
      end else begin
         case (state)
            IDLE: if (sample_valid) begin
               data_q  <= sample_data;
               label_q <= sample_label;
               sum     <= '0;
               idx     <= '0;
            end
            ACCUM: begin
               if (data_q[idx]) sum <= op_y;
               idx <= idx + 1'b1;
            end
            DECIDE: begin
               pred_q <= pred_now;
               err_q  <= pred_now ^ label_q;
               idx    <= '0;
            end
            UPDATE: begin
               if (data_q[idx]) weights[idx] <= op_y;
               idx <= idx + 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign sample_ready = (state == IDLE);
   assign busy         = (state != IDLE);
   assign done_valid   = (state == DONE);
   assign done_pred    = pred_q;
   assign done_err     = err_q;
   assign weight_data  = weights[weight_addr];

endmodule

// File: tb/tb_perceptron_trainer.sv
// Scoreboard bench for perceptron_trainer: directed samples push expected
// results; a negedge monitor pops and checks each done pulse.
`timescale 1ns/1ps
module tb_perceptron_trainer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        sample_valid = 1'b0;
   logic        sample_ready;
   logic [15:0] sample_data = '0;
   logic        sample_label = 1'b0;
   logic        done_valid, done_pred, done_err, busy;
   logic [3:0]  weight_addr = '0;
   logic [7:0]  weight_data;

   typedef struct {
      logic pred;
      logic err;
      int   lat;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   hs_cyc = 0;
   int   done_seen = 0;

   perceptron_trainer #(
      .N_IN(16), .W_WIDTH(8), .LR(8'd16), .THRESH(8'd255), .W_INIT(8'h80)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .sample_valid (sample_valid),
      .sample_ready (sample_ready),
      .sample_data  (sample_data),
      .sample_label (sample_label),
      .done_valid   (done_valid),
      .done_pred    (done_pred),
      .done_err     (done_err),
      .busy         (busy),
      .weight_addr  (weight_addr),
      .weight_data  (weight_data)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: every done pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (rst_n && done_valid) begin
         done_seen++;
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done actual=1 expected=0 (t=%0t)", $time);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("done_pred", int'(done_pred), int'(e.pred));
            chk("done_err", int'(done_err), int'(e.err));
            chk("done_latency", cyc - hs_cyc + 1, e.lat);
         end
      end
   end

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic check_weights(input logic [7:0] w0, input logic [7:0] w1, input string tag);
      logic [7:0] exp_w;
      @(negedge clk);
      for (int a = 0; a < 16; a++) begin
         weight_addr = 4'(a);
         #0.2;
         exp_w = (a == 0) ? w0 : (a == 1) ? w1 : 8'h80;
         chk($sformatf("%s_w%0d", tag, a), int'(weight_data), int'(exp_w));
      end
   endtask

   task automatic issue(input logic [15:0] d, input logic l);
      int waited = 0;
      while (!sample_ready && waited < 100) begin
         @(negedge clk);
         waited++;
      end
      chk("ready_wait", int'(sample_ready), 1);
      sample_valid = 1'b1;
      sample_data  = d;
      sample_label = l;
      @(posedge clk);
      #1;
      hs_cyc       = cyc;
      sample_valid = 1'b0;
      sample_data  = ~d;
      sample_label = ~l;
   endtask

   task automatic run(input logic [15:0] d, input logic l,
                      input logic ep, input logic ee, input int elat);
      int target;
      target = done_seen + 1;
      sb.push_back('{pred: ep, err: ee, lat: elat});
      issue(d, l);
      for (int i = 0; i < 60 && done_seen < target; i++) @(negedge clk);
      chk("done_timeout", int'(done_seen >= target), 1);
   endtask

   logic [7:0] sat_tbl [9] = '{8'h90, 8'hA0, 8'hB0, 8'hC0, 8'hD0, 8'hE0, 8'hF0, 8'hFF, 8'hFF};

   initial begin
      do_reset();
      chk("rst_ready", int'(sample_ready), 1);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done_valid", int'(done_valid), 0);
      check_weights(8'h80, 8'h80, "rst");

      // 128+128 saturates to 255 -> predict 1, correct
      run(16'h0003, 1'b1, 1'b1, 1'b0, 18);
      check_weights(8'h80, 8'h80, "noerr");

      // sum 128 < 255 -> predict 0, label 1 -> weight[0] += 16
      run(16'h0001, 1'b1, 1'b0, 1'b1, 34);
      check_weights(8'h90, 8'h80, "inc");

      do_reset();
      run(16'h0003, 1'b0, 1'b1, 1'b1, 34);
      check_weights(8'h70, 8'h70, "dec");

      do_reset();
      for (int k = 0; k < 9; k++) begin
         if (k < 8) run(16'h0001, 1'b1, 1'b0, 1'b1, 34);
         else       run(16'h0001, 1'b1, 1'b1, 1'b0, 18);
         check_weights(sat_tbl[k], 8'h80, $sformatf("sat%0d", k + 1));
      end

      // Reset inside UPDATE: no done pulse, weights back to initial value
      do_reset();
      issue(16'hFFFF, 1'b0);
      for (int i = 0; i < 40 && (cyc - hs_cyc + 1) < 25; i++) @(negedge clk);
      chk("mid_cycle", cyc - hs_cyc + 1, 25);
      chk("mid_busy_before", int'(busy), 1);
      rst_n = 1'b0;
      #1;
      chk("mid_ready", int'(sample_ready), 1);
      chk("mid_busy", int'(busy), 0);
      chk("mid_done_valid", int'(done_valid), 0);
      check_weights(8'h80, 8'h80, "mid_rst");
      rst_n = 1'b1;
      repeat (40) @(negedge clk);
      chk("mid_ready_after", int'(sample_ready), 1);
      check_weights(8'h80, 8'h80, "mid_after");

      chk("sb_empty", sb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
